// File: rtl/alu_pkg.sv
// Shared definitions for the TP1 ALU datapath: default widths, opcode codes,
// debouncer and loader-sequencer state encodings.
package alu_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefOpW   = 6;

   // ALU function codes carried on the low switch bits
   localparam logic [5:0] OpAdd = 6'b100000;
   localparam logic [5:0] OpSub = 6'b100010;
   localparam logic [5:0] OpAnd = 6'b100100;
   localparam logic [5:0] OpOr  = 6'b100101;
   localparam logic [5:0] OpXor = 6'b100110;
   localparam logic [5:0] OpSra = 6'b000011;
   localparam logic [5:0] OpSrl = 6'b000010;
   localparam logic [5:0] OpNor = 6'b100111;

   typedef enum logic [1:0] {
      StIdleLo,
      StCheckHi,
      StIdleHi,
      StCheckLo
   } deb_state_e;

   typedef enum logic [1:0] {
      StWaitA,
      StWaitB,
      StWaitOp,
      StDone
   } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, debounce FSM with stability
// counter, and a single-cycle press pulse on an accepted rising level.
module btn_debounce
   import alu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   deb_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Synchronizer, FSM state and counter registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= StIdleLo;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a level change must persist DEBOUNCE_CYCLES checked cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdleLo: begin
            if (sync2_q) begin
               state_d = StCheckHi;
               cnt_d   = '0;
            end
         end
         StCheckHi: begin
            if (!sync2_q)              state_d = StIdleLo;
            else if (cnt_q == CntLast) state_d = StIdleHi;
            else                       cnt_d   = cnt_q + CntW'(1);
         end
         StIdleHi: begin
            if (!sync2_q) begin
               state_d = StCheckLo;
               cnt_d   = '0;
            end
         end
         StCheckLo: begin
            if (sync2_q)               state_d = StIdleHi;
            else if (cnt_q == CntLast) state_d = StIdleLo;
            else                       cnt_d   = cnt_q + CntW'(1);
         end
         default: state_d = StIdleLo;
      endcase
   end

   // Press pulse on the cycle the high level is accepted; release is silent
   always_comb begin
      press_o = (state_q == StCheckHi) && sync2_q && (cnt_q == CntLast);
   end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand loader: captures A, B and opcode from a shared switch bus on
// debounced button presses. Define LOADER_SEQ_EN to enforce A -> B -> Op order.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W          = DefDataW,
   parameter int unsigned OP_W            = DefOpW,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_sw,
   input  logic              i_btn_a,
   input  logic              i_btn_b,
   input  logic              i_btn_op,
   output logic [DATA_W-1:0] o_a,
   output logic [DATA_W-1:0] o_b,
   output logic [OP_W-1:0]   o_op,
   output logic              o_valid,
   output logic              o_ready
);

   logic              pulse_a, pulse_b, pulse_op;
   logic              ld_a, ld_b, ld_op;
   logic [DATA_W-1:0] a_q, b_q;
   logic [OP_W-1:0]   op_q;
   logic              valid_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (i_btn_a),
      .press_o(pulse_a)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (i_btn_b),
      .press_o(pulse_b)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (i_btn_op),
      .press_o(pulse_op)
   );

`ifdef LOADER_SEQ_EN
   seq_state_e seq_q, seq_d;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!rst_n) seq_q <= StWaitA;
      else        seq_q <= seq_d;
   end

   // Sequencer next state: advance only on the expected button
   always_comb begin
      seq_d = seq_q;
      unique case (seq_q)
         StWaitA:  if (pulse_a)  seq_d = StWaitB;
         StWaitB:  if (pulse_b)  seq_d = StWaitOp;
         StWaitOp: if (pulse_op) seq_d = StDone;
         StDone:   seq_d = StDone;
         default:  seq_d = StWaitA;
      endcase
   end

   // Sequencer outputs: gate loads to the expected register until done
   always_comb begin
      ld_a  = 1'b0;
      ld_b  = 1'b0;
      ld_op = 1'b0;
      unique case (seq_q)
         StWaitA:  ld_a  = pulse_a;
         StWaitB:  ld_b  = pulse_b;
         StWaitOp: ld_op = pulse_op;
         StDone: begin
            ld_a  = pulse_a;
            ld_b  = pulse_b;
            ld_op = pulse_op;
         end
         default: ;
      endcase
   end

   assign o_ready = (seq_q == StDone);
`else
   logic [2:0] loaded_q;

   // Sticky per-register loaded flags
   always_ff @(posedge clk) begin
      if (!rst_n) loaded_q <= '0;
      else        loaded_q <= loaded_q | {ld_op, ld_b, ld_a};
   end

   // Any order accepted
   always_comb begin
      ld_a  = pulse_a;
      ld_b  = pulse_b;
      ld_op = pulse_op;
   end

   assign o_ready = &loaded_q;
`endif

   // Operand/opcode registers and single valid pulse per update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         if (ld_a)  a_q  <= i_sw;
         if (ld_b)  b_q  <= i_sw;
         if (ld_op) op_q <= i_sw[OP_W-1:0];
         valid_q <= ld_a | ld_b | ld_op;
      end
   end

   assign o_a     = a_q;
   assign o_b     = b_q;
   assign o_op    = op_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES = 4.
module tb_alu_operand_loader;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_sw;
   logic       i_btn_a, i_btn_b, i_btn_op;
   logic [7:0] o_a, o_b;
   logic [5:0] o_op;
   logic       o_valid, o_ready;

   int errors = 0;
   int checks = 0;
   int vcount;

   alu_operand_loader #(
      .DATA_W         (8),
      .OP_W           (6),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sw    (i_sw),
      .i_btn_a (i_btn_a),
      .i_btn_b (i_btn_b),
      .i_btn_op(i_btn_op),
      .o_a     (o_a),
      .o_b     (o_b),
      .o_op    (o_op),
      .o_valid (o_valid),
      .o_ready (o_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Count o_valid cycles over n clocks
   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (o_valid) cnt++;
      end
   endtask

   function automatic logic [7:0] sra8(input logic [7:0] a, input logic [7:0] sh);
      logic signed [7:0] sa;
      sa = a;
      return 8'(sa >>> sh[2:0]);
   endfunction

   initial begin
      rst_n    = 1'b0;
      i_sw     = 8'h00;
      i_btn_a  = 1'b0;
      i_btn_b  = 1'b0;
      i_btn_op = 1'b0;
      tick();
      tick();
      chk("rst_a", 32'(o_a), 32'h0);
      chk("rst_b", 32'(o_b), 32'h0);
      chk("rst_op", 32'(o_op), 32'h0);
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_ready", 32'(o_ready), 32'h0);
      rst_n = 1'b1;
      tick();

      // Load A: register must update exactly at edge 7
      i_sw    = 8'b0000_1011;
      i_btn_a = 1'b1;
      repeat (6) tick();
      chk("a_edge6", 32'(o_a), 32'h0);
      chk("valid_edge6", 32'(o_valid), 32'h0);
      tick();
      chk("a_edge7", 32'(o_a), 32'h0B);
      chk("valid_edge7", 32'(o_valid), 32'h1);
      chk("b_after_a", 32'(o_b), 32'h0);
      chk("op_after_a", 32'(o_op), 32'h0);
      chk("ready_after_a", 32'(o_ready), 32'h0);
      tick();
      chk("valid_edge8", 32'(o_valid), 32'h0);
      count_valid(12, vcount);
      chk("hold_single_load", 32'(vcount), 32'h0);
      i_btn_a = 1'b0;
      repeat (10) tick();

      // Glitch on B shorter than N: no load
      i_sw    = 8'hFF;
      i_btn_b = 1'b1;
      repeat (3) tick();
      i_btn_b = 1'b0;
      count_valid(12, vcount);
      chk("glitch_valid", 32'(vcount), 32'h0);
      chk("glitch_b", 32'(o_b), 32'h0);
      chk("glitch_a_kept", 32'(o_a), 32'h0B);

      // Load B = 1
      i_sw    = 8'd1;
      i_btn_b = 1'b1;
      repeat (7) tick();
      chk("b_load", 32'(o_b), 32'h01);
      chk("b_valid", 32'(o_valid), 32'h1);
      chk("ready_after_b", 32'(o_ready), 32'h0);
      i_btn_b = 1'b0;
      repeat (10) tick();

      // Load Op = SRA, ready rises with the third load
      i_sw     = {2'b00, OpSra};
      i_btn_op = 1'b1;
      repeat (6) tick();
      chk("ready_before_op", 32'(o_ready), 32'h0);
      tick();
      chk("op_load", 32'(o_op), 32'(OpSra));
      chk("ready_after_op", 32'(o_ready), 32'h1);
      chk("sra_result", 32'(sra8(o_a, o_b)), 32'h05);
      i_btn_op = 1'b0;
      repeat (10) tick();

      // Simultaneous A and B: same edge, one valid pulse
      i_sw    = 8'h80;
      i_btn_a = 1'b1;
      i_btn_b = 1'b1;
      repeat (6) tick();
      chk("sim_a_pre", 32'(o_a), 32'h0B);
      chk("sim_b_pre", 32'(o_b), 32'h01);
      tick();
      chk("sim_a", 32'(o_a), 32'h80);
      chk("sim_b", 32'(o_b), 32'h80);
      chk("sim_valid", 32'(o_valid), 32'h1);
      tick();
      chk("sim_valid_once", 32'(o_valid), 32'h0);
      chk("sim_ready_sticky", 32'(o_ready), 32'h1);
      i_btn_a = 1'b0;
      i_btn_b = 1'b0;
      repeat (10) tick();

      // Reset mid-hold of Op; re-qualified N+3 edges after release
      i_sw     = 8'h07;
      i_btn_op = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_a", 32'(o_a), 32'h0);
      chk("mid_rst_b", 32'(o_b), 32'h0);
      chk("mid_rst_op", 32'(o_op), 32'h0);
      chk("mid_rst_valid", 32'(o_valid), 32'h0);
      chk("mid_rst_ready", 32'(o_ready), 32'h0);
      rst_n = 1'b1;
      repeat (6) tick();
      chk("requal_op_edge6", 32'(o_op), 32'h0);
      tick();
`ifdef LOADER_SEQ_EN
      chk("seq_op_ignored", 32'(o_op), 32'h0);
      chk("seq_op_novalid", 32'(o_valid), 32'h0);
`else
      chk("requal_op_edge7", 32'(o_op), 32'h07);
      chk("requal_valid", 32'(o_valid), 32'h1);
      chk("requal_ready", 32'(o_ready), 32'h0);
`endif
      i_btn_op = 1'b0;
      repeat (10) tick();

`ifdef LOADER_SEQ_EN
      // Out-of-order B is ignored, then A, B, Op in order
      i_sw    = 8'h22;
      i_btn_b = 1'b1;
      repeat (8) tick();
      chk("seq_b_first", 32'(o_b), 32'h0);
      i_btn_b = 1'b0;
      repeat (10) tick();
      i_sw    = 8'h11;
      i_btn_a = 1'b1;
      repeat (8) tick();
      chk("seq_a", 32'(o_a), 32'h11);
      i_btn_a = 1'b0;
      repeat (10) tick();
      i_sw    = 8'h22;
      i_btn_b = 1'b1;
      repeat (8) tick();
      chk("seq_b", 32'(o_b), 32'h22);
      chk("seq_ready_pre", 32'(o_ready), 32'h0);
      i_btn_b = 1'b0;
      repeat (10) tick();
      i_sw     = {2'b00, OpAdd};
      i_btn_op = 1'b1;
      repeat (7) tick();
      chk("seq_op", 32'(o_op), 32'(OpAdd));
      chk("seq_ready", 32'(o_ready), 32'h1);
      i_btn_op = 1'b0;
      repeat (10) tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
